// File: rtl/an_encoder_n13_pkg.sv
// Constants and state type shared by the AN-code encoder and decoder,
// so both sides always agree on A and the codeword width.
package an_pkg;
  localparam int AN_A      = 13;
  localparam int AN_A_W    = 4;
  localparam int AN_DATA_W = 3;
  localparam int AN_CW_W   = AN_DATA_W + AN_A_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} an_enc_state_t;
endpackage

// File: rtl/an_encoder_n13_if.sv
// Source/sink handshake bundle of the AN encoder: word in, codeword out.
interface an_encoder_n13_if #(
  parameter int DATA_W = an_pkg::AN_DATA_W,
  parameter int CW_W   = an_pkg::AN_CW_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic [CW_W-1:0]   inj_mask;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   codeword;
  logic              busy;

  modport master (
    output in_valid, data, inj_mask, out_ready,
    input  in_ready, out_valid, codeword, busy
  );

  modport slave (
    input  in_valid, data, inj_mask, out_ready,
    output in_ready, out_valid, codeword, busy
  );
endinterface

// File: rtl/an_encoder_n13.sv
// Sequential AN-code encoder: codeword = A*data built by shift-and-add,
// one data bit per cycle, with an optional XOR fault mask for decoder tests.
module an_encoder_n13
  import an_pkg::*;
#(
  parameter int DATA_W = AN_DATA_W,
  parameter int A      = AN_A,
  parameter int A_W    = AN_A_W,
  parameter int CW_W   = DATA_W + A_W
) (
  input  logic              clk,
  input  logic              rst,
  an_encoder_n13_if.slave   bus
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  an_enc_state_t     state_q, state_d;
  logic [CW_W-1:0]   acc_q,   acc_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] d_q,     d_d;
  logic [CW_W-1:0]   m_q,     m_d;

  logic [DATA_W-1:0] d_sh;
  logic [CW_W-1:0]   addend;

  // Partial product for the current bit: A shifted into place, or nothing.
  always_comb begin
    d_sh   = d_q >> idx_q;
    addend = d_sh[0] ? (CW_W'(A) << idx_q) : '0;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    d_d     = d_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          d_d     = bus.data;
          m_d     = bus.inj_mask;
          acc_d   = '0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      d_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      m_q     <= m_d;
    end
  end

  // Outputs decode registered state only; codeword is forced to 0 outside DONE.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.codeword  = (state_q == DONE) ? (acc_q ^ m_q) : '0;
  end
endmodule
